// File: rtl/led_pattern_gen.sv
// LED pattern generator: selectable animated 4-bit patterns advanced by a
// step prescaler, gated by a free-running PWM for brightness, with mode
// changes taken over a valid/ready handshake.
module led_pattern_gen #(
    parameter int PRESCALE = 31250000,
    parameter int PWM_BITS = 4
) (
    input  logic                clk_125,
    input  logic                rst,
    input  logic [2:0]          mode_in,
    input  logic                mode_valid,
    output logic                mode_ready,
    input  logic [PWM_BITS-1:0] duty,
    output logic [3:0]          led,
    output logic                step
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic {
        S_LOAD,
        S_RUN
    } state_e;

    typedef enum logic [2:0] {
        M_OFF     = 3'd0,
        M_SHIFT_L = 3'd1,
        M_SHIFT_R = 3'd2,
        M_BLINK   = 3'd3,
        M_COUNT   = 3'd4,
        M_BOUNCE  = 3'd5
    } mode_e;

    typedef enum logic {
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

    state_e              state;
    state_e              state_next;
    mode_e               mode;
    dir_e                dir;
    dir_e                dir_next;
    logic [3:0]          pat;
    logic [3:0]          pat_next;
    logic [3:0]          pat_init;
    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                accept_load;
    logic                advance;
    logic                en;

    assign tick = (prescaler == PS_LAST);
    assign en   = (duty == '1) || (pwm_cnt < duty);

    // FSM state register
    always_ff @(posedge clk_125) begin
        if (!rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake ready, and arbitration of accept versus tick
    always_comb begin
        state_next  = state;
        mode_ready  = 1'b0;
        accept_load = 1'b0;
        advance     = 1'b0;
        case (state)
            S_LOAD: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                mode_ready = 1'b1;
                // Codes 6/7 complete the handshake but are dropped here, so
                // they neither reload nor block a coincident pattern advance.
                accept_load = mode_valid && (mode_in <= 3'd5);
                advance     = tick && !accept_load;
                if (accept_load) begin
                    state_next = S_LOAD;
                end
            end
            default: begin
                state_next = S_LOAD;
            end
        endcase
    end

    // Initial pattern per mode and next pattern/direction on a step
    always_comb begin
        pat_init = 4'b0000;
        pat_next = pat;
        dir_next = dir;
        case (mode)
            M_SHIFT_L: pat_init = 4'b0001;
            M_SHIFT_R: pat_init = 4'b1000;
            M_BLINK:   pat_init = 4'b1111;
            M_BOUNCE:  pat_init = 4'b0001;
            default:   pat_init = 4'b0000;
        endcase
        case (mode)
            M_OFF:     pat_next = 4'b0000;
            M_SHIFT_L: pat_next = {pat[2:0], pat[3]};
            M_SHIFT_R: pat_next = {pat[0], pat[3:1]};
            M_BLINK:   pat_next = ~pat;
            M_COUNT:   pat_next = pat + 4'd1;
            M_BOUNCE: begin
                if (dir == DIR_LEFT) begin
                    if (pat == 4'b1000) begin
                        pat_next = 4'b0100;
                        dir_next = DIR_RIGHT;
                    end else begin
                        pat_next = pat << 1;
                    end
                end else begin
                    if (pat == 4'b0001) begin
                        pat_next = 4'b0010;
                        dir_next = DIR_LEFT;
                    end else begin
                        pat_next = pat >> 1;
                    end
                end
            end
            default:   pat_next = pat;
        endcase
    end

    // Mode latch, pattern, prescaler, PWM counter and registered outputs
    always_ff @(posedge clk_125) begin
        if (!rst) begin
            mode      <= M_OFF;
            pat       <= '0;
            dir       <= DIR_LEFT;
            prescaler <= '0;
            pwm_cnt   <= '0;
            led       <= '0;
            step      <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            led     <= pat & {4{en}};
            step    <= 1'b0;
            if (state == S_LOAD) begin
                pat       <= pat_init;
                dir       <= DIR_LEFT;
                prescaler <= '0;
            end else begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (accept_load) begin
                    mode <= mode_e'(mode_in);
                end
                if (advance) begin
                    pat  <= pat_next;
                    dir  <= dir_next;
                    step <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: expected outputs are queued as each
// cycle's stimulus is driven and popped/compared just after the clock edge.
module tb_led_pattern_gen;

    localparam int PRESCALE = 4;
    localparam int PWM_BITS = 4;

    logic                clk_125 = 1'b0;
    logic                rst;
    logic [2:0]          mode_in;
    logic                mode_valid;
    logic                mode_ready;
    logic [PWM_BITS-1:0] duty;
    logic [3:0]          led;
    logic                step;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [3:0] led;
        logic       step;
        logic       ready;
    } exp_t;

    exp_t                sb[$];
    logic [3:0]          seq[$];
    logic [3:0]          cur_pat;
    logic [PWM_BITS-1:0] pwm_ref;

    led_pattern_gen #(
        .PRESCALE(PRESCALE),
        .PWM_BITS(PWM_BITS)
    ) dut (
        .clk_125   (clk_125),
        .rst       (rst),
        .mode_in   (mode_in),
        .mode_valid(mode_valid),
        .mode_ready(mode_ready),
        .duty      (duty),
        .led       (led),
        .step      (step)
    );

    always #4 clk_125 = ~clk_125;

    // Free-running PWM phase reference: cleared by reset, wraps at 2^PWM_BITS
    always @(posedge clk_125) begin
        pwm_ref <= !rst ? '0 : pwm_ref + 1'b1;
    end

    function automatic logic en_now();
        return (duty == '1) || (pwm_ref < duty);
    endfunction

    task automatic push_exp(input string tag, input logic [3:0] l, input logic s, input logic r);
        exp_t e;
        e.tag   = tag;
        e.led   = l;
        e.step  = s;
        e.ready = r;
        sb.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk_125);
        #1;
        e = sb.pop_front();
        vectors++;
        assert (led === e.led) else begin
            miscompares++;
            $error("FAIL %s led: got %b expected %b", e.tag, led, e.led);
        end
        vectors++;
        assert (step === e.step) else begin
            miscompares++;
            $error("FAIL %s step: got %b expected %b", e.tag, step, e.step);
        end
        vectors++;
        assert (mode_ready === e.ready) else begin
            miscompares++;
            $error("FAIL %s mode_ready: got %b expected %b", e.tag, mode_ready, e.ready);
        end
    endtask

    // Accept edge then LOAD edge; LED still shows the old pattern for both.
    task automatic send_mode(input logic [2:0] m, input string name);
        mode_in    = m;
        mode_valid = 1'b1;
        push_exp({name, " accept"}, cur_pat & {4{en_now()}}, 1'b0, 1'b0);
        cycle();
        mode_valid = 1'b0;
        push_exp({name, " load"}, cur_pat & {4{en_now()}}, 1'b0, 1'b1);
        cycle();
    endtask

    // k counts edges after the LOAD edge: the pattern advances on every
    // PRESCALE-th edge and the LED shows it one edge later.
    task automatic follow(input string name, input int unsigned ncyc);
        for (int unsigned k = 1; k <= ncyc; k++) begin
            push_exp($sformatf("%s k=%0d", name, k), seq[(k - 1) / PRESCALE] & {4{en_now()}},
                     (k % PRESCALE) == 0, 1'b1);
            cycle();
        end
        cur_pat = seq[ncyc / PRESCALE];
    endtask

    initial begin
        rst        = 1'b0;
        duty       = '1;
        mode_in    = 3'd0;
        mode_valid = 1'b0;
        cur_pat    = 4'b0000;

        // Reset held for three edges, then release into LOAD -> RUN
        for (int i = 0; i < 3; i++) begin
            push_exp("reset", 4'b0000, 1'b0, 1'b0);
            cycle();
        end
        rst = 1'b1;
        push_exp("release", 4'b0000, 1'b0, 1'b1);
        cycle();

        // SHIFT_L
        seq = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        send_mode(3'd1, "shl");
        follow("shl", 17);

        // BOUNCE over 8 steps
        seq = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
        send_mode(3'd5, "bounce");
        follow("bounce", 33);

        // COUNT through a full wrap
        seq.delete();
        for (int i = 0; i < 17; i++) seq.push_back(4'(i));
        send_mode(3'd4, "count");
        follow("count", 65);

        // mode_valid held high: accepted only on ready cycles
        mode_in    = 3'd3;
        mode_valid = 1'b1;
        push_exp("hold a1", 4'b0000, 1'b0, 1'b0); cycle();
        push_exp("hold l1", 4'b0000, 1'b0, 1'b1); cycle();
        push_exp("hold a2", 4'b1111, 1'b0, 1'b0); cycle();
        push_exp("hold l2", 4'b1111, 1'b0, 1'b1); cycle();
        mode_valid = 1'b0;
        seq.delete();
        for (int i = 0; i < 9; i++) seq.push_back((i % 2 == 0) ? 4'b1111 : 4'b0000);
        cur_pat = 4'b1111;
        follow("blink", 9);

        // Mode 7: handshake completes, pattern continues without reload
        mode_in    = 3'd7;
        mode_valid = 1'b1;
        push_exp("m7 accept", 4'b1111, 1'b0, 1'b1); cycle();
        mode_valid = 1'b0;
        push_exp("m7 run1", 4'b1111, 1'b0, 1'b1); cycle();
        push_exp("m7 tick", 4'b1111, 1'b1, 1'b1); cycle();
        push_exp("m7 run2", 4'b0000, 1'b0, 1'b1); cycle();
        push_exp("m7 run3", 4'b0000, 1'b0, 1'b1); cycle();
        push_exp("m7 run4", 4'b0000, 1'b0, 1'b1); cycle();

        // Accept coinciding with tick: no step, reload to SHIFT_R start
        mode_in    = 3'd2;
        mode_valid = 1'b1;
        push_exp("tick accept", 4'b0000, 1'b0, 1'b0); cycle();
        mode_valid = 1'b0;
        push_exp("tick load", 4'b0000, 1'b0, 1'b1); cycle();
        seq = {4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        cur_pat = 4'b1000;
        follow("shr", 17);

        // PWM brightness in BLINK
        seq.delete();
        for (int i = 0; i < 9; i++) seq.push_back((i % 2 == 0) ? 4'b1111 : 4'b0000);
        duty = 4'd4;
        send_mode(3'd3, "pwm4");
        follow("pwm4", 33);
        duty = 4'd0;
        send_mode(3'd3, "pwm0");
        follow("pwm0", 9);
        duty = 4'd15;
        send_mode(3'd3, "pwm15");
        follow("pwm15", 9);

        // Mid-operation reset in COUNT at pat=0101 on a tick edge
        seq.delete();
        for (int i = 0; i < 17; i++) seq.push_back(4'(i));
        send_mode(3'd4, "cnt2");
        follow("cnt2", 23);
        rst = 1'b0;
        push_exp("midrst", 4'b0000, 1'b0, 1'b0); cycle();
        rst = 1'b1;
        push_exp("midrst load", 4'b0000, 1'b0, 1'b1); cycle();
        seq = {4'b0000, 4'b0000, 4'b0000};
        cur_pat = 4'b0000;
        follow("off", 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
